uart_tx: RTL and testbench

8N1 UART transmitter, the transmit-side counterpart of uart_rx, sharing its bit timing from src/uart_defs.v.
- Accepts bytes over a valid/ready handshake into a one-entry holding register.
- Serialises bytes LSB-first on serial_out, each bit held for BIT_DURATION clocks.
- The holding register double-buffers, so back-to-back bytes go out with no idle gap between frames.

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/uart_etu_counter.sv | 40 ++++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the 8N1 UART transmitter: frame geometry, FSM encoding
// and the holding-register payload.
package uart_tx_pkg;

    localparam int unsigned UART_BIT_DURATION = 16;
    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_ETU_WIDTH    = 10;
    localparam int unsigned UART_IDX_WIDTH    = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    typedef struct packed {
        logic       full;
        uart_byte_t data;
    } tx_hold_t;

endpackage

// File: rtl/uart_etu_counter.sv
// Elementary-time-unit counter: counts 0..BIT_DURATION-1 and wraps, with a
// registered bit_done flag that is high while the count sits on its last value.
module uart_etu_counter
    import uart_tx_pkg::*;
#(
    parameter int unsigned BIT_DURATION = UART_BIT_DURATION
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam logic [UART_ETU_WIDTH-1:0] LAST = UART_ETU_WIDTH'(BIT_DURATION - 1);

    logic [UART_ETU_WIDTH-1:0] etu_q, etu_d;
    logic                      bit_done_q, bit_done_d;

    // Flag is computed from the next count so it lines up with etu_q == LAST.
    always_comb begin
        etu_d      = etu_q + UART_ETU_WIDTH'(1);
        if (clear || (etu_q == LAST)) begin
            etu_d = '0;
        end
        bit_done_d = (etu_d == LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            etu_q      <= '0;
            bit_done_q <= 1'b0;
        end else begin
            etu_q      <= etu_d;
            bit_done_q <= bit_done_d;
        end
    end

    assign bit_done = bit_done_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register that double-buffers
// the shifter, allowing gapless back-to-back frames.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned BIT_DURATION = UART_BIT_DURATION
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      serial_out,
    output logic                      busy
);

    localparam logic [UART_IDX_WIDTH-1:0] LAST_IDX = UART_IDX_WIDTH'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    tx_hold_t                  hold_q, hold_d;
    uart_byte_t                shift_q, shift_d;
    logic [UART_IDX_WIDTH-1:0] idx_q, idx_d;
    logic                      serial_q, serial_d;
    logic                      busy_q, busy_d;
    logic                      load_c;
    logic                      etu_clear;
    logic                      bit_done;

    // Counter is held at zero while idle so every frame starts on a fresh ETU.
    assign etu_clear = (state_q == TX_IDLE);

    uart_etu_counter #(
        .BIT_DURATION (BIT_DURATION)
    ) u_etu (
        .clk      (clk),
        .reset    (reset),
        .clear    (etu_clear),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        serial_d = serial_q;
        load_c   = 1'b0;

        // Accept only into an empty holding register; a full one is never overwritten.
        if (tx_valid && !hold_q.full) begin
            hold_d.full = 1'b1;
            hold_d.data = tx_data;
        end

        case (state_q)
            TX_IDLE: begin
                serial_d = 1'b1;
                if (hold_q.full && enable) begin
                    load_c = 1'b1;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    serial_d = shift_q[0];
                    idx_d    = '0;
                    state_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_IDX) begin
                        serial_d = 1'b1;
                        state_d  = TX_STOP;
                    end else begin
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                        idx_d    = idx_q + UART_IDX_WIDTH'(1);
                    end
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    if (hold_q.full && enable) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d  = TX_IDLE;
                serial_d = 1'b1;
            end
        endcase

        // Moving the held byte into the shifter starts a frame (load and accept are exclusive).
        if (load_c) begin
            shift_d     = hold_q.data;
            hold_d.full = 1'b0;
            serial_d    = 1'b0;
            state_d     = TX_START;
        end

        busy_d = (state_d != TX_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= TX_IDLE;
            hold_q   <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
        end
    end

    assign tx_ready   = ~hold_q.full;
    assign serial_out = serial_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random bytes compared against an ideal 8N1
// line waveform computed from bit position arithmetic.
module tb_uart_tx;

    localparam int BD    = 16;
    localparam int FRAME = 10 * BD;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic line_log  [0:4095];
    logic busy_log  [0:4095];
    logic ready_log [0:4095];

    always #5 clk = ~clk;

    uart_tx #(.BIT_DURATION(BD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .busy       (busy)
    );

    // Ideal line level t clocks after the start-bit falling edge.
    function automatic logic frame_level(input logic [7:0] b, input int t);
        int bit_no;
        bit_no = t / BD;
        if (bit_no == 0) return 1'b0;
        if (bit_no <= 8) return b[bit_no-1];
        return 1'b1;
    endfunction

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            line_log[i]  = serial_out;
            busy_log[i]  = busy;
            ready_log[i] = tx_ready;
        end
    endtask

    task automatic test_reset;
        int lows, busys, notready;
        reset = 1'b1; enable = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: serial=%b busy=%b ready=%b, required 1 0 1", serial_out, busy, tx_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (1 + 2*BD + 5) @(negedge clk);
        checks++;
        if (serial_out !== 1'b0) begin
            errors++;
            $display("FAIL midframe_bit1: serial=%b, required 0", serial_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midframe: serial=%b busy=%b ready=%b, required 1 0 1", serial_out, busy, tx_ready);
        end
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        record(3*BD);
        lows = 0; busys = 0; notready = 0;
        for (int i = 0; i < 3*BD; i++) begin
            if (line_log[i] !== 1'b1) lows++;
            if (busy_log[i] !== 1'b0) busys++;
            if (ready_log[i] !== 1'b1) notready++;
        end
        checks++;
        if (lows != 0 || busys != 0 || notready != 0) begin
            errors++;
            $display("FAIL reset_quiet: lows=%0d busy=%0d notready=%0d, required all 0", lows, busys, notready);
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        int mism, busys, trail;
        @(negedge clk);
        tx_data = b; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0; tx_data = 8'($urandom());
        record(FRAME + 4);
        checks++;
        if (line_log[0] !== 1'b1 || ready_log[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_latency %h: serial=%b ready=%b one cycle after accept, required 1 0", b, line_log[0], ready_log[0]);
        end
        checks++;
        if (ready_log[1] !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_return %h: ready=%b, required 1", b, ready_log[1]);
        end
        mism = 0; busys = 0; trail = 0;
        for (int t = 0; t < FRAME; t++) if (line_log[t+1] !== frame_level(b, t)) mism++;
        for (int i = 0; i < FRAME + 4; i++) if (busy_log[i] === 1'b1) busys++;
        for (int i = FRAME + 1; i < FRAME + 4; i++) if (line_log[i] !== 1'b1) trail++;
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL single_wave %h: %0d mismatching clocks, required 0", b, mism);
        end
        checks++;
        if (busys != FRAME || trail != 0) begin
            errors++;
            $display("FAIL single_busy %h: busy clocks=%0d trailing lows=%0d, required %0d 0", b, busys, trail, FRAME);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
        int mism, busys, trail, accept_k;
        logic got;
        @(negedge clk);
        tx_data = a; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = b;
        accept_k = -1; got = 1'b0;
        fork
            record(2*FRAME + 4);
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (tx_ready === 1'b1) begin
                        got = 1'b1; accept_k = k;
                        break;
                    end
                end
                @(posedge clk);
                #1 tx_valid = 1'b0; tx_data = ~b;
            end
        join
        checks++;
        if (!got || accept_k != 1) begin
            errors++;
            $display("FAIL b2b_accept %h/%h: second accept after %0d cycles, required 1", a, b, accept_k);
        end
        mism = 0; busys = 0; trail = 0;
        for (int t = 0; t < 2*FRAME; t++) begin
            if (t < FRAME) begin
                if (line_log[t+1] !== frame_level(a, t)) mism++;
            end else begin
                if (line_log[t+1] !== frame_level(b, t - FRAME)) mism++;
            end
        end
        for (int i = 0; i < 2*FRAME + 4; i++) if (busy_log[i] === 1'b1) busys++;
        for (int i = 2*FRAME + 1; i < 2*FRAME + 4; i++) if (line_log[i] !== 1'b1) trail++;
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL b2b_wave %h/%h: %0d mismatching clocks, required 0", a, b, mism);
        end
        checks++;
        if (busys != 2*FRAME || trail != 0) begin
            errors++;
            $display("FAIL b2b_busy %h/%h: busy clocks=%0d trailing lows=%0d, required %0d 0", a, b, busys, trail, 2*FRAME);
        end
    endtask

    task automatic test_enable_hold(input logic [7:0] a);
        int lows, busys, readys, mism, trail;
        enable = 1'b0;
        @(negedge clk);
        tx_data = a; tx_valid = 1'b1;
        @(posedge clk);
        #1;
        lows = 0; busys = 0; readys = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
            if (tx_ready !== 1'b0) readys++;
            tx_data = 8'($urandom());
        end
        tx_valid = 1'b0;
        checks++;
        if (lows != 0 || busys != 0 || readys != 0) begin
            errors++;
            $display("FAIL hold_quiet %h: lows=%0d busy=%0d ready=%0d, required all 0", a, lows, busys, readys);
        end
        enable = 1'b1;
        record(FRAME + 3*BD);
        mism = 0; busys = 0; trail = 0;
        for (int t = 0; t < FRAME; t++) if (line_log[t] !== frame_level(a, t)) mism++;
        for (int i = 0; i < FRAME + 3*BD; i++) if (busy_log[i] === 1'b1) busys++;
        for (int i = FRAME; i < FRAME + 3*BD; i++) if (line_log[i] !== 1'b1) trail++;
        checks++;
        if (mism != 0 || ready_log[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_wave %h: %0d mismatching clocks ready=%b, required 0 1", a, mism, ready_log[0]);
        end
        checks++;
        if (busys != FRAME || trail != 0) begin
            errors++;
            $display("FAIL hold_once %h: busy clocks=%0d trailing lows=%0d, required %0d 0", a, busys, trail, FRAME);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(8'h55);
        repeat (4) test_single(8'($urandom()));
        test_back_to_back(8'h13, 8'h37);
        repeat (2) test_back_to_back(8'($urandom()), 8'($urandom()));
        test_enable_hold(8'hA5);
        test_enable_hold(8'($urandom()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
